// File: rtl/mul8_sequencer_if.sv
// rtl/mul8_sequencer_if.sv - start/busy/done handshake and shared-adder operand bus for mul8_sequencer
interface mul8_sequencer_if;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;

    // Requester side: issues operands and models the external adder
    modport master (
        output start, multiplicand, multiplier, add_sum, add_cout,
        input  busy, done, product, add_a, add_b
    );

    // Sequencer side
    modport slave (
        input  start, multiplicand, multiplier, add_sum, add_cout,
        output busy, done, product, add_a, add_b
    );
endinterface

// File: rtl/mul8_sequencer.sv
// rtl/mul8_sequencer.sv - 8x8 shift-and-add multiplier sequenced over a shared 8-bit adder (option: MUL8_ZERO_BYPASS_EN)
module mul8_sequencer #(
    parameter int ADD_SETTLE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mul8_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADD, WAIT, DONE} state_t;

    localparam logic [1:0] SETTLE = 2'(ADD_SETTLE);

    state_t      state;
    logic [7:0]  acc;
    logic [7:0]  q;
    logic [7:0]  m;
    logic [3:0]  cnt;
    logic [1:0]  wcnt;
    logic [15:0] product_r;
    logic        busy_r;
    logic        done_r;

    // The 9-bit adder result shifts right into ACC:Q, so the carry lands in ACC[7]
    logic [7:0] acc_next;
    logic [7:0] q_next;
    assign acc_next = {bus.add_cout, bus.add_sum[7:1]};
    assign q_next   = {bus.add_sum[0], q[7:1]};

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

    // Operands reach the adder only while an iteration is in flight
    always_comb begin
        bus.add_a = '0;
        bus.add_b = '0;
        if (state == ADD || state == WAIT) begin
            bus.add_a = acc;
            bus.add_b = q[0] ? m : '0;
        end
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        acc    <= '0;
                        q      <= bus.multiplier;
                        m      <= bus.multiplicand;
                        cnt    <= 4'd8;
                        wcnt   <= SETTLE;
`ifdef MUL8_ZERO_BYPASS_EN
                        if (bus.multiplicand == 8'd0 || bus.multiplier == 8'd0) begin
                            product_r <= '0;
                            done_r    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= (ADD_SETTLE == 0) ? ADD : WAIT;
                        end
`else
                        state <= (ADD_SETTLE == 0) ? ADD : WAIT;
`endif
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - 2'd1;
                    if (wcnt == 2'd1) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc <= acc_next;
                    q   <= q_next;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        product_r <= {acc_next, q_next};
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end else if (ADD_SETTLE != 0) begin
                        wcnt  <= SETTLE;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
